// File: rtl/ucsbece154a_memarb.sv
// rtl/ucsbece154a_memarb.sv - two-requester arbiter and access sequencer for a single-ported unified memory
//
// Serialises instruction-fetch and load/store requests onto one memory port.
// Each access runs IDLE -> BUSY (1 + WAIT_CYCLES cycles) -> DONE. Read data is
// captured on the last BUSY cycle, and the owner's done pulse is high for the
// single DONE cycle. Misaligned accesses report err_o with done, and
// misaligned stores never assert the write enable.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   if_req_i, if_a_i                fetch request and byte address
//   if_done_o, if_rd_o              fetch done pulse and fetched word
//   d_req_i, d_we_i, d_a_i, d_wd_i  data request, store flag, address, store data
//   d_done_o, d_rd_o                data done pulse and load word
//   err_o                           misaligned flag, valid with done
//   mem_a_o, mem_we_o, mem_wd_o     memory address, write enable, write data
//   mem_rd_i                        combinational memory read data
module ucsbece154a_memarb #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_a_i,
    output logic        if_done_o,
    output logic [31:0] if_rd_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_a_i,
    input  logic [31:0] d_wd_i,
    output logic        d_done_o,
    output logic [31:0] d_rd_o,
    output logic        err_o,
    output logic [31:0] mem_a_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester encoding used by owner and last: 0 = fetch, 1 = data.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    state_t           state;
    state_t           state_next;
    logic             last;
    logic             owner;
    logic             we_l;
    logic             mis;
    logic [CNT_W-1:0] cnt;
    logic             grant_if;
    logic             grant_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Grant decode: on contention the requester that did not win last time
    // gets the port, so fetch and data alternate while both stay asserted.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE) begin
            if (if_req_i && d_req_i) begin
                if (last == REQ_D) begin
                    grant_if = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end else if (d_req_i) begin
                grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_if || grant_d) state_next = BUSY;
            BUSY:    if (cnt_zero) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded from state so that an asynchronous reset drops a pending write
    // at once; the single write edge lands on the last BUSY cycle.
    assign mem_we_o = (state == BUSY) && cnt_zero && we_l && !mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= REQ_D;
            owner     <= REQ_IF;
            we_l      <= 1'b0;
            mis       <= 1'b0;
            cnt       <= '0;
            mem_a_o   <= 32'h0;
            mem_wd_o  <= 32'h0;
            if_rd_o   <= 32'h0;
            d_rd_o    <= 32'h0;
            if_done_o <= 1'b0;
            d_done_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            // Done and error are pulses: only the BUSY->DONE edge raises them.
            if_done_o <= 1'b0;
            d_done_o  <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        owner   <= REQ_IF;
                        last    <= REQ_IF;
                        mem_a_o <= {if_a_i[31:2], 2'b00};
                        we_l    <= 1'b0;
                        mis     <= |if_a_i[1:0];
                        cnt     <= CNT_W'(WAIT_CYCLES);
                    end else if (grant_d) begin
                        owner    <= REQ_D;
                        last     <= REQ_D;
                        mem_a_o  <= {d_a_i[31:2], 2'b00};
                        mem_wd_o <= d_wd_i;
                        we_l     <= d_we_i;
                        mis      <= |d_a_i[1:0];
                        cnt      <= CNT_W'(WAIT_CYCLES);
                    end
                end
                BUSY: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        err_o <= mis;
                        if (owner == REQ_D) begin
                            d_rd_o   <= mem_rd_i;
                            d_done_o <= 1'b1;
                        end else begin
                            if_rd_o   <= mem_rd_i;
                            if_done_o <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ucsbece154a_memarb.md
Name: ucsbece154a_memarb

Overview:
Two-requester arbiter and access sequencer for the single-ported unified instruction/data memory of the multicycle RISC-V core. It accepts instruction-fetch and load/store requests and serialises them onto the one memory port. It models a configurable number of memory wait states, captures read data and returns a one-cycle done pulse to the owning requester. Misaligned accesses are flagged, and misaligned writes are suppressed.

Parameters:
WAIT_CYCLES, 0, extra BUSY cycles per access before data is captured (0..15).
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
if_req_i  input  1  instruction-fetch request; sampled only in IDLE.
if_a_i  input  32  fetch byte address.
if_done_o  output  1  one-cycle pulse: fetch complete, if_rd_o valid.
if_rd_o  output  32  fetched word; held until the next fetch done.
d_req_i  input  1  data request; sampled only in IDLE.
d_we_i  input  1  1 = store, 0 = load.
d_a_i  input  32  data byte address.
d_wd_i  input  32  store data.
d_done_o  output  1  one-cycle pulse: data access complete.
d_rd_o  output  32  load word; held until the next data done.
err_o  output  1  high with done when the completed access was misaligned.
mem_a_o  output  32  address to memory, word-aligned (bits [1:0] forced to 0).
mem_we_o  output  1  memory write enable.
mem_wd_o  output  32  memory write data.
mem_rd_i  input  32  combinational memory read data.

Behaviour:
- States: IDLE, BUSY, DONE. All outputs are registered except mem_we_o.
- Reset values: state=IDLE, last=DATA, all done outputs 0, err_o 0, mem_a_o 0, mem_wd_o 0, if_rd_o 0, d_rd_o 0, counter 0. mem_we_o is 0 immediately on reset assertion, because it is decoded from state.
- IDLE, no request: stay in IDLE; mem_* hold their values; mem_we_o=0.
- IDLE, one request: grant that requester.
  - Latch owner, address with [1:0] cleared, we (0 for fetch), wd, and mis=|a[1:0].
  - Load counter with WAIT_CYCLES; go to BUSY.
- IDLE, both requests: grant the requester not recorded in `last`. After reset, fetch therefore wins first. `last` updates to the owner at each grant.
- BUSY: mem_a_o = latched address.
  - Counter != 0: decrement, stay in BUSY.
  - Counter == 0: mem_we_o = we & ~mis for this cycle only. Capture mem_rd_i into the owner's rd register; go to DONE.
- DONE: the owner's done_o=1 for exactly one cycle, err_o=mis; then go to IDLE. The other done output stays 0.
- Latency: request sampled in IDLE at cycle N -> BUSY cycles N+1 .. N+1+WAIT_CYCLES -> done at N+2+WAIT_CYCLES. Minimum is 2 cycles with WAIT_CYCLES=0.
- Write timing: exactly one write edge per store, on the last BUSY cycle. Stores never write in IDLE or DONE.
- Requests are not sampled in BUSY or DONE. A request still high in the IDLE after DONE is a new access.
- Requester addresses and data may change after grant; latched copies are used.
- Misaligned access: the access is still performed at the aligned address and err_o=1 with done. For a store, mem_we_o is never asserted. For a load or fetch, the aligned word is returned.
- Reset mid-access: return to IDLE immediately. No done pulse is produced, a pending write is dropped, and rd registers return to 0.
- The arbiter never drives z; address-range decode remains the memory's job.

Test Plan:
1. Reset, then if_req_i=1, if_a_i=0x00010004, WAIT_CYCLES=0, mem_rd_i=0x00500093 -> mem_a_o=0x00010004 in BUSY; if_done_o pulses 2 cycles after sampling; if_rd_o=0x00500093; d_done_o=0.
2. Simultaneous if_req_i and d_req_i held high, 4 accesses -> grants in order fetch, data, fetch, data; each done is a single pulse.
3. Store d_a_i=0x10000008, d_wd_i=0xDEADBEEF, WAIT_CYCLES=3 -> mem_we_o high for exactly one cycle, 4 cycles after sampling, with mem_wd_o=0xDEADBEEF; d_done_o pulses the next cycle; err_o=0.
4. Misaligned store d_a_i=0x10000006 -> mem_a_o=0x10000004; mem_we_o never high; d_done_o=1 with err_o=1.
5. Assert reset in the second BUSY cycle of a store with WAIT_CYCLES=3 -> mem_we_o stays 0; no done pulse; state is IDLE. Next if_req_i is serviced normally.
6. Change d_a_i and d_wd_i during BUSY -> the memory sees the originally latched values.
